// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timer_sequencer
// Purpose  : Periodic tick generator with finite/continuous bursts, pause/stop.
// Revision : 1.0  initial release
// ============================================================================
module timer_sequencer #(
    parameter int COUNT_WIDTH = 10,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   i_START,
    input  logic                   i_STOP,
    input  logic                   i_PAUSE,
    input  logic [COUNT_WIDTH-1:0] i_PERIOD,
    input  logic [BURST_WIDTH-1:0] i_BURST,
    output logic [COUNT_WIDTH-1:0] o_CNT,
    output logic                   o_TICK,
    output logic [BURST_WIDTH-1:0] o_BURST_CNT,
    output logic                   o_DONE,
    output logic                   o_BUSY,
    output logic [1:0]             o_STATE
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] C_CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BURST_WIDTH-1:0] C_BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_period;
    logic [BURST_WIDTH-1:0] r_burst;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [BURST_WIDTH-1:0] r_burst_cnt;
    logic                   r_tick;
    logic                   r_done;

    logic [COUNT_WIDTH-1:0] w_period_last;
    logic [BURST_WIDTH-1:0] w_burst_next;

    // r_period is never 0 while running, so period-1 cannot underflow.
    assign w_period_last = r_period - C_CNT_ONE;
    assign w_burst_next  = r_burst_cnt + C_BURST_ONE;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state     <= S_IDLE;
            r_period    <= '0;
            r_burst     <= '0;
            r_cnt       <= '0;
            r_burst_cnt <= '0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            if (i_STOP) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_burst_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (i_START) begin
                            r_period    <= (i_PERIOD == '0) ? C_CNT_ONE : i_PERIOD;
                            r_burst     <= i_BURST;
                            r_cnt       <= '0;
                            r_burst_cnt <= '0;
                            r_state     <= S_RUN;
                        end
                    end
                    S_RUN, S_PAUSED: begin
                        // The edge that leaves PAUSED already counts, so a pause
                        // of N sampled edges delays the next tick by exactly N.
                        if (i_PAUSE) begin
                            r_state <= S_PAUSED;
                        end else if (r_cnt == w_period_last) begin
                            r_cnt       <= '0;
                            r_tick      <= 1'b1;
                            r_burst_cnt <= w_burst_next;
                            if ((r_burst != '0) && (w_burst_next == r_burst)) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end else begin
                            r_cnt   <= r_cnt + C_CNT_ONE;
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_STATE     = r_state;
    assign o_CNT       = r_cnt;
    assign o_BURST_CNT = r_burst_cnt;
    assign o_TICK      = r_tick;
    assign o_DONE      = r_done;
    assign o_BUSY      = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_sequencer
// Purpose  : Scenario bench for timer_sequencer with a tick-time scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] period = '0;
    logic [7:0] burst = '0;
    logic [9:0] cnt;
    logic       tick;
    logic [7:0] burst_cnt;
    logic       done;
    logic       busy;
    logic [1:0] state;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int obs_q[$];
    int done_q[$];

    timer_sequencer #(.COUNT_WIDTH(10), .BURST_WIDTH(8)) dut (
        .i_CLK(clk), .i_RST(rst), .i_START(start), .i_STOP(stop),
        .i_PAUSE(pause), .i_PERIOD(period), .i_BURST(burst),
        .o_CNT(cnt), .o_TICK(tick), .o_BURST_CNT(burst_cnt),
        .o_DONE(done), .o_BUSY(busy), .o_STATE(state)
    );

    always #5 clk = ~clk;

    // Advance one edge, then sample just after it and log tick/done edges.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (tick) obs_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_checks++;
        if ({state, cnt, burst_cnt, tick, done, busy} !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got state=%0d cnt=%0d bcnt=%0d tick=%b done=%b busy=%b, want all 0",
                     state, cnt, burst_cnt, tick, done, busy);
        end
        step();
        rst = 1'b0;
        period = 10'd3;
        burst = 8'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            period = period + 10'd1;
        end
        n_checks++;
        if (state !== 2'd0 || busy !== 1'b0 || cnt !== 10'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got state=%0d busy=%b cnt=%0d, want 0 0 0", state, busy, cnt);
        end
    endtask

    task automatic test_burst();
        int k, e, o;
        clear_sb();
        period = 10'd4; burst = 8'd3; start = 1'b1;
        step();
        k = cyc;
        start = 1'b0;
        exp_q.push_back(k + 4); exp_q.push_back(k + 8); exp_q.push_back(k + 12);
        for (int i = 0; i < 16; i++) step();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL burst_tick_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL burst_tick_time: got edge %0d, want edge %0d", o - k, e - k);
            end
        end
        n_checks++;
        if (done_q.size() != 1 || (done_q.size() == 1 && done_q[0] != k + 12)) begin
            n_errors++;
            $display("FAIL burst_done: got %0d strobes (first at %0d), want 1 at edge 12",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] - k : -1);
        end
        n_checks++;
        if (state !== 2'd3 || burst_cnt !== 8'd3 || cnt !== 10'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL burst_final: got state=%0d bcnt=%0d cnt=%0d busy=%b, want 3 3 0 0",
                     state, burst_cnt, cnt, busy);
        end
    endtask

    task automatic test_continuous();
        int k, e, o, bad;
        bit busy_ok;
        clear_sb();
        busy_ok = 1'b1;
        bad = 0;
        period = 10'd0; burst = 8'd0; start = 1'b1;
        step();
        k = cyc;
        start = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            exp_q.push_back(k + n);
            step();
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == 255) begin
                n_checks++;
                if (burst_cnt !== 8'd255) begin
                    n_errors++;
                    $display("FAIL cont_bcnt_255: got %0d, want 255", burst_cnt);
                end
            end
            if (n == 256) begin
                n_checks++;
                if (burst_cnt !== 8'd0) begin
                    n_errors++;
                    $display("FAIL cont_bcnt_wrap: got %0d, want 0", burst_cnt);
                end
            end
        end
        n_checks++;
        if (!busy_ok) begin
            n_errors++;
            $display("FAIL cont_busy: got busy low during run, want always 1");
        end
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL cont_tick_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o != e) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL cont_tick_time: got %0d misplaced ticks, want 0", bad);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (state !== 2'd0 || cnt !== 10'd0 || burst_cnt !== 8'd0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL cont_stop: got state=%0d cnt=%0d bcnt=%0d tick=%b, want 0 0 0 0",
                     state, cnt, burst_cnt, tick);
        end
    endtask

    task automatic test_pause();
        int k, e, o;
        clear_sb();
        period = 10'd5; burst = 8'd0; start = 1'b1;
        step();
        k = cyc;
        start = 1'b0;
        step(); step();
        n_checks++;
        if (cnt !== 10'd2) begin
            n_errors++;
            $display("FAIL pause_precount: got cnt=%0d, want 2", cnt);
        end
        // Undelayed first tick would be at k+5; three paused edges move it to k+8.
        exp_q.push_back(k + 8); exp_q.push_back(k + 13);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (state !== 2'd2 || cnt !== 10'd2 || busy !== 1'b1 || tick !== 1'b0) begin
                n_errors++;
                $display("FAIL pause_hold[%0d]: got state=%0d cnt=%0d busy=%b tick=%b, want 2 2 1 0",
                         i, state, cnt, busy, tick);
            end
        end
        pause = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL pause_tick_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL pause_tick_time: got edge %0d, want edge %0d", o - k, e - k);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_stop();
        clear_sb();
        period = 10'd8; burst = 8'd0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL start_stop_same_edge: got state=%0d busy=%b, want 0 0", state, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (cnt !== 10'd3 || state !== 2'd1) begin
            n_errors++;
            $display("FAIL stop_precount: got cnt=%0d state=%0d, want 3 1", cnt, state);
        end
        stop = 1'b1; pause = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0;
        n_checks++;
        if (state !== 2'd0 || cnt !== 10'd0 || burst_cnt !== 8'd0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_run: got state=%0d cnt=%0d bcnt=%0d tick=%b, want 0 0 0 0",
                     state, cnt, burst_cnt, tick);
        end
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (obs_q.size() != 0 || state !== 2'd0) begin
            n_errors++;
            $display("FAIL stop_quiet: got %0d ticks state=%0d, want 0 ticks state 0", obs_q.size(), state);
        end
    endtask

    task automatic test_reset_midrun();
        period = 10'd10; burst = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 27; i++) step();
        n_checks++;
        if (cnt !== 10'd7 || burst_cnt !== 8'd2) begin
            n_errors++;
            $display("FAIL midrun_precond: got cnt=%0d bcnt=%0d, want 7 2", cnt, burst_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({state, cnt, burst_cnt, tick, done, busy} !== 23'd0) begin
            n_errors++;
            $display("FAIL midrun_async_reset: got state=%0d cnt=%0d bcnt=%0d tick=%b done=%b busy=%b, want all 0",
                     state, cnt, burst_cnt, tick, done, busy);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (state !== 2'd0 || cnt !== 10'd0) begin
            n_errors++;
            $display("FAIL midrun_stay_idle: got state=%0d cnt=%0d, want 0 0", state, cnt);
        end
    endtask

    task automatic test_start_ignored();
        int k, e, o;
        clear_sb();
        period = 10'd4; burst = 8'd0; start = 1'b1;
        step();
        k = cyc;
        start = 1'b0;
        for (int n = 1; n <= 4; n++) exp_q.push_back(k + 4 * n);
        step(); step();
        start = 1'b1; period = 10'd2; burst = 8'd1;
        step(); step();
        start = 1'b0;
        for (int i = 0; i < 13; i++) step();
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_errors++;
            $display("FAIL restart_tick_count: got %0d, want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_errors++;
                $display("FAIL restart_tick_time: got edge %0d, want edge %0d", o - k, e - k);
            end
        end
        n_checks++;
        if (state !== 2'd1 || done_q.size() != 0) begin
            n_errors++;
            $display("FAIL restart_still_running: got state=%0d done strobes=%0d, want 1 0",
                     state, done_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_continuous();
        test_pause();
        test_stop();
        test_reset_midrun();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter COUNT_WIDTH, default 10, width of the period counter and period input.
REQ-002 Parameter BURST_WIDTH, default 8, width of the burst-length input and burst counter.
REQ-003 The block SHALL have port i_CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_RST, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_START, input, 1, start request, sampled each edge.
REQ-006 The block SHALL have port i_STOP, input, 1, abort request, sampled each edge.
REQ-007 The block SHALL have port i_PAUSE, input, 1, level; holds the count while high.
REQ-008 The block SHALL have port i_PERIOD, input, COUNT_WIDTH, tick period in cycles.
REQ-009 The block SHALL have port i_BURST, input, BURST_WIDTH, ticks per run; 0 = continuous.
REQ-010 The block SHALL have port o_CNT, output, COUNT_WIDTH, current period count.
REQ-011 The block SHALL have port o_TICK, output, 1, one-cycle strobe at each period rollover.
REQ-012 The block SHALL have port o_BURST_CNT, output, BURST_WIDTH, ticks issued in the current run.
REQ-013 The block SHALL have port o_DONE, output, 1, one-cycle strobe when a finite burst completes.
REQ-014 The block SHALL have port o_BUSY, output, 1, high in RUN or PAUSED.
REQ-015 The block SHALL have port o_STATE, output, 2, state: IDLE=0, RUN=1, PAUSED=2, DONE=3.

Function
REQ-016 All outputs SHALL be registered; o_BUSY SHALL be decoded from registered state only.
REQ-017 In IDLE or DONE, i_START high SHALL latch i_PERIOD and i_BURST, clear o_CNT and o_BURST_CNT, and enter RUN.
REQ-018 A latched period of 0 SHALL be treated as 1 (tick every cycle).
REQ-019 In RUN with i_PAUSE low, o_CNT SHALL increment by 1 per edge.
REQ-020 When o_CNT equals latched period-1 in RUN, the next edge SHALL set o_CNT to 0, assert o_TICK for one cycle and increment o_BURST_CNT.
REQ-021 With START sampled on edge k and period P, the first o_TICK SHALL be high in the cycle after edge k+P; subsequent ticks every P cycles.
REQ-022 If latched burst B is nonzero and the tick brings o_BURST_CNT to B, the same edge SHALL enter DONE and assert o_DONE for one cycle; o_CNT SHALL be 0 and o_BURST_CNT SHALL equal B in DONE.
REQ-023 With latched burst 0, o_BURST_CNT SHALL wrap modulo 2^BURST_WIDTH and the run SHALL never end by itself.
REQ-024 In RUN, i_PAUSE high SHALL enter PAUSED with o_CNT and o_BURST_CNT held and no tick issued on that edge.
REQ-025 In PAUSED, i_PAUSE low SHALL return to RUN, with counting resuming on the following edge.
REQ-026 i_START in RUN or PAUSED SHALL be ignored; latched period and burst SHALL be unchanged.
REQ-027 i_STOP in any state SHALL enter IDLE, clear o_CNT and o_BURST_CNT, and suppress o_TICK and o_DONE on that edge.
REQ-028 i_STOP and i_START high on the same edge SHALL resolve as STOP; the block SHALL end in IDLE.
REQ-029 i_STOP and i_PAUSE high on the same edge SHALL resolve as STOP.
REQ-030 Changes on i_PERIOD or i_BURST outside the START edge SHALL have no effect.
REQ-031 o_TICK and o_DONE SHALL be low in every cycle not named above.

Reset
REQ-032 i_RST high SHALL immediately force o_STATE=IDLE, o_CNT=0, o_BURST_CNT=0, o_TICK=0, o_DONE=0, o_BUSY=0 and clear latched period and burst, including mid-run.
REQ-033 After i_RST falls, the block SHALL remain in IDLE until a sampled i_START.

Verification
REQ-034 The bench SHALL cover: PERIOD=4, BURST=3, START at edge 0 -> o_TICK after edges 4, 8, 12; o_DONE with the third tick; o_STATE=3, o_BURST_CNT=3.
REQ-035 The bench SHALL cover: PERIOD=0, BURST=0 -> o_TICK every cycle, o_BURST_CNT wraps 255->0, o_BUSY stays 1.
REQ-036 The bench SHALL cover: PERIOD=5, i_PAUSE high for 3 cycles at o_CNT=2 -> o_STATE=2, o_CNT holds 2, tick delayed by exactly 3 cycles.
REQ-037 The bench SHALL cover: i_START and i_STOP on the same edge in IDLE, then i_STOP at o_CNT=3 in RUN -> IDLE, o_CNT=0, no o_TICK.
REQ-038 The bench SHALL cover: i_RST asserted mid-run at o_CNT=7, o_BURST_CNT=2 -> all outputs 0 asynchronously, o_STATE=0.
REQ-039 The bench SHALL cover: i_START during RUN with a new i_PERIOD -> ignored, tick spacing unchanged.
